ppm_decoder: RTL and testbench
==============================

// Module: ppm_decoder
// PURPOSE
//  Receive side of the PPM link: recovers the pulse position (0..2^W-1) of one pulse per frame.
//  Local frame counter aligned by frame_sync; first rising edge of pulse_in per frame captured.
//  Result delivered through a valid/ready port; missing, extra and overrun conditions flagged.
//  Sits between the PPM pad input and the position consumer in the top-level wrapper.
// PARAMETERS
//  W           8   counter/position width; frame length = 2^W cycles
//  POS_OFFSET  0   subtracted (mod 2^W) from the captured count to cancel the transmit/pad latency
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  ena          in   1  1 = run; 0 = all state holds, pulse_in ignored
//  frame_sync   in   1  1-cycle strobe; the cycle it is high is frame position 0
//  pulse_in     in   1  PPM pulse stream
//  pos_data     out  W  decoded position
//  pos_valid    out  1  pos_data valid; held until accepted
//  pos_ready    in   1  consumer accepts when pos_valid & pos_ready
//  err_missing  out  1  1-cycle strobe: closed frame contained no rising edge
//  err_multi    out  1  1-cycle strobe: closed frame contained >1 rising edge
//  err_overrun  out  1  1-cycle strobe: new result overwrote an unaccepted one
//  locked       out  1  1 once the first frame_sync is seen
// BEHAVIOUR
//  Reset: cnt=0, state=IDLE, all outputs 0 (pos_data=0).
//  cnt_eff = frame_sync ? 0 : cnt; cnt <= cnt_eff + 1 (wraps 2^W-1 -> 0).
//  Edge: p = pulse sample (see CONFIGURATION), edge = p & ~p_d.
//  FSM: IDLE -(frame_sync)-> SEARCH -(edge)-> HOLD; frame close returns to SEARCH.
//   IDLE: edges ignored, no errors; locked=0. Leaving IDLE sets locked=1 (sticky until rst).
//  Capture: first edge in a frame stores (cnt_eff - POS_OFFSET) mod 2^W; later edges only count.
//  Edge counter saturates at 2.
//  Frame close: cycle with cnt_eff == 2^W-1, or a frame_sync arriving before that (early resync).
//   Early resync: old frame closes on edges seen before the sync cycle; an edge on the sync
//   cycle belongs to the new frame at position 0.
//  On close (outputs updated next cycle): 0 edges -> err_missing; 1 -> load result;
//   >=2 -> load first-edge result and pulse err_multi.
//  Load: pos_data <= result, pos_valid <= 1. If pos_valid & ~pos_ready that cycle -> overwrite,
//   err_overrun=1. Same-cycle accept and load -> new result valid, no overrun.
//  pos_valid drops the cycle after pos_valid & pos_ready with no new load.
//  Latency: pos_valid rises 1 cycle after the frame's last cycle (frame_sync at t0 -> t0+2^W).
//  Mid-operation rst: immediate return to reset state, pending result dropped, lock lost.
//  ena=0: cnt, FSM, p_d and outputs hold; error strobes forced 0.
// CONFIGURATION
//  PPM_SYNC_EN defined: pulse_in passes a 2-flop synchronizer (reset 0) before edge detect;
//   the 2 extra cycles are subtracted internally in addition to POS_OFFSET.
//  Undefined: pulse_in sampled directly (p = pulse_in); caller guarantees it is synchronous to clk.
// STRUCTURE
//  ppm_pkg: FSM state enum {IDLE,SEARCH,HOLD}, SYNC_STAGES=2.
//  Sub-module ppm_pulse_sync: optional synchronizer + p_d register + edge output.
//  Top holds counter, FSM, result/handshake and error logic.
// TESTING
//  W=8, POS_OFFSET=0, no PPM_SYNC_EN:
//  1 frame_sync@t0, pulse high t0+37 for 1 cycle, pos_ready=1 -> pos_data=37, pos_valid@t0+256 1 cycle.
//  2 no pulse for a full frame -> err_missing 1 cycle @t0+256, pos_valid stays 0.
//  3 pulses @t0+10 and t0+200 -> pos_data=10 and err_multi, both @t0+256.
//  4 pos_ready=0, pulses @5 then @9 in consecutive frames -> pos_data=9, err_overrun once, valid held.
//  5 second frame_sync @t0+100, pulse t0+100 -> old frame err_missing; new frame pos_data=0.
//  6 rst high mid-frame after pulse -> all outputs 0, locked=0, no result; pulses before next frame_sync ignored.
//  Repeat 1 with PPM_SYNC_EN -> pos_data=37.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared definitions for the PPM receive path.
// Holds the decoder FSM state encoding and the synchronizer depth.
// Optional feature macro: PPM_SYNC_EN (see ppm_pulse_sync).
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ppm_pulse_sync.sv
// Purpose: sample pulse_in (optionally through a 2-flop synchronizer) and flag rising edges.
// Latency: rise is combinational from the sample; the synchronizer adds SYNC_STAGES cycles.
// Backpressure: none; ena=0 freezes all flops so no edge is lost or invented while stalled.
// Ports: clk, rst (async, active high), ena, pulse_in -> rise (1 on a 0->1 transition of the sample).
// Macro PPM_SYNC_EN: defined = synchronizer in path; undefined = pulse_in used directly.
module ppm_pulse_sync
    import ppm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic pulse_in,
    output logic rise
);

    logic p;
    logic p_d;

`ifdef PPM_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else if (ena) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
        end
    end

    assign p = sync_q[SYNC_STAGES-1];
`else
    assign p = pulse_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_d <= 1'b0;
        end else if (ena) begin
            p_d <= p;
        end
    end

    assign rise = p & ~p_d;

endmodule

// File: rtl/ppm_decoder.sv
// Purpose: recover the pulse position of one PPM pulse per 2^W-cycle frame aligned by frame_sync.
// Latency: pos_valid rises 1 cycle after the last cycle of the frame (sync at t0 -> valid at t0+2^W).
// Backpressure: pos_valid/pos_data held until pos_ready; a newer result overwrites and pulses err_overrun.
// Ports: clk, rst (async, active high), ena, frame_sync, pulse_in, pos_ready in;
//        pos_data[W-1:0], pos_valid, err_missing, err_multi, err_overrun, locked out.
// Macro PPM_SYNC_EN: inserts the pulse synchronizer; its delay is removed from the captured position.
module ppm_decoder
    import ppm_pkg::*;
#(
    parameter int W          = 8,
    parameter int POS_OFFSET = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         frame_sync,
    input  logic         pulse_in,
    output logic [W-1:0] pos_data,
    output logic         pos_valid,
    input  logic         pos_ready,
    output logic         err_missing,
    output logic         err_multi,
    output logic         err_overrun,
    output logic         locked
);

`ifdef PPM_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif
    // Total correction applied to the raw count, reduced mod 2^W by truncation.
    localparam logic [W-1:0] CORR    = W'(POS_OFFSET + LAT);
    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;
    logic [W-1:0] cap;
    logic [W-1:0] first_pos;
    logic [1:0]   n_edges;
    logic         rise;

    logic         close;
    logic [1:0]   cl_n;
    logic [W-1:0] cl_pos;

    ppm_pulse_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    assign cnt_eff = frame_sync ? '0 : cnt;
    assign cap     = cnt_eff - CORR;

    // Summary of the frame being closed this cycle. A natural close (last
    // position) includes this cycle's edge; an early resync does not, because
    // an edge on the sync cycle belongs to the new frame. A sync landing at
    // cnt==0 only realigns: the previous frame already closed on wrap.
    always_comb begin
        close  = 1'b0;
        cl_n   = n_edges;
        cl_pos = first_pos;
        if (state != IDLE) begin
            if (frame_sync) begin
                close = (cnt != '0);
            end else if (cnt == CNT_MAX) begin
                close = 1'b1;
                if (rise) begin
                    cl_n = (n_edges == 2'd2) ? 2'd2 : n_edges + 2'd1;
                    if (n_edges == 2'd0) begin
                        cl_pos = cap;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            first_pos   <= '0;
            n_edges     <= 2'd0;
            pos_data    <= '0;
            pos_valid   <= 1'b0;
            err_missing <= 1'b0;
            err_multi   <= 1'b0;
            err_overrun <= 1'b0;
            locked      <= 1'b0;
        end else if (ena) begin
            err_missing <= 1'b0;
            err_multi   <= 1'b0;
            err_overrun <= 1'b0;
            cnt         <= cnt_eff + W'(1);

            // Frame tracking: a sync always opens a fresh frame at position 0.
            if (frame_sync) begin
                locked  <= 1'b1;
                state   <= rise ? HOLD : SEARCH;
                n_edges <= {1'b0, rise};
                if (rise) begin
                    first_pos <= cap;
                end
            end else if (state != IDLE) begin
                if (cnt == CNT_MAX) begin
                    state   <= SEARCH;
                    n_edges <= 2'd0;
                end else if (rise) begin
                    if (state == SEARCH) begin
                        first_pos <= cap;
                    end
                    state   <= HOLD;
                    n_edges <= (n_edges == 2'd2) ? 2'd2 : n_edges + 2'd1;
                end
            end

            // Result port: an accept drops valid unless a new load lands in the same cycle.
            if (pos_valid && pos_ready) begin
                pos_valid <= 1'b0;
            end
            if (close) begin
                if (cl_n == 2'd0) begin
                    err_missing <= 1'b1;
                end else begin
                    pos_data    <= cl_pos;
                    pos_valid   <= 1'b1;
                    err_multi   <= (cl_n == 2'd2);
                    err_overrun <= pos_valid & ~pos_ready;
                end
            end
        end else begin
            err_missing <= 1'b0;
            err_multi   <= 1'b0;
            err_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppm_decoder.sv
module tb_ppm_decoder;

    localparam int W   = 8;
    localparam int N   = 1 << W;
    localparam int OFF = 0;
`ifdef PPM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         frame_sync;
    logic         pulse_in;
    logic         pos_ready;
    logic [W-1:0] pos_data;
    logic         pos_valid;
    logic         err_missing;
    logic         err_multi;
    logic         err_overrun;
    logic         locked;

    always #5 clk = ~clk;

    ppm_decoder #(.W(W), .POS_OFFSET(OFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .frame_sync  (frame_sync),
        .pulse_in    (pulse_in),
        .pos_data    (pos_data),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .err_missing (err_missing),
        .err_multi   (err_multi),
        .err_overrun (err_overrun),
        .locked      (locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    // The current frame is a list of edge positions; when a frame ends the
    // list decides the outcome: empty -> missing, otherwise first entry is
    // the result, more than one -> multi.
    bit m_locked;
    int m_pos;           // position the next cycle will have if no sync arrives
    int m_edges[$];
    bit m_dly[2];
    bit m_prev;
    bit m_valid;
    int m_data;
    bit m_miss, m_multi, m_over;

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_edges.delete();
        m_dly[0] = 0; m_dly[1] = 0; m_prev = 0;
        m_valid = 0; m_data = 0;
        m_miss = 0; m_multi = 0; m_over = 0;
    endtask

    task automatic end_frame(input bit rdy, inout bit loaded);
        if (m_edges.size() == 0) begin
            m_miss = 1;
        end else begin
            m_over  = m_valid && !rdy;
            m_valid = 1;
            m_data  = m_edges[0];
            m_multi = (m_edges.size() >= 2);
            loaded  = 1;
        end
        m_edges.delete();
    endtask

    task automatic model_step(input bit fs, input bit pin, input bit rdy, input bit en);
        bit p, e, acc, loaded;
        int pos;
        m_miss = 0; m_multi = 0; m_over = 0;
        if (!en) return;
        p = (LAT == 0) ? pin : m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = pin;
        e = p && !m_prev;
        m_prev = p;
        pos = fs ? 0 : m_pos;
        acc = m_valid && rdy;
        loaded = 0;
        if (m_locked) begin
            // A sync where the next frame begins anyway closes nothing.
            if (fs && m_pos != 0) end_frame(rdy, loaded);
            if (e) m_edges.push_back(((pos - LAT - OFF) % N + N) % N);
            if (!fs && pos == N - 1) end_frame(rdy, loaded);
        end else if (fs) begin
            m_locked = 1;
            if (e) m_edges.push_back(((pos - LAT - OFF) % N + N) % N);
        end
        if (acc && !loaded) m_valid = 0;
        m_pos = (pos + 1) % N;
    endtask

    task automatic compare_all(input string ph);
        chk({ph, "_valid"},   32'(pos_valid),   32'(m_valid));
        if (m_valid) chk({ph, "_data"}, 32'(pos_data), 32'(m_data));
        chk({ph, "_missing"}, 32'(err_missing), 32'(m_miss));
        chk({ph, "_multi"},   32'(err_multi),   32'(m_multi));
        chk({ph, "_overrun"}, 32'(err_overrun), 32'(m_over));
        chk({ph, "_locked"},  32'(locked),      32'(m_locked));
    endtask

    // One clock cycle: apply inputs, advance model, sample #1 after the edge.
    task automatic cycle(input bit fs, input bit pin, input bit rdy, input bit en, input string ph);
        frame_sync = fs; pulse_in = pin; pos_ready = rdy; ena = en;
        if (rst) model_reset();
        else     model_step(fs, pin, rdy, en);
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    int since_fs;
    int target;
    int hold;
    bit fs, pin;

    initial begin
        rst = 1'b1; ena = 1'b0; frame_sync = 1'b0; pulse_in = 1'b0; pos_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset_data", 32'(pos_data), 32'd0);
        rst = 1'b0;

        // Directed: sync at t0, single pulse at t0+37, consumer always ready.
        cycle(1, 0, 1, 1, "t1");
        for (int k = 1; k < N; k++) begin
            cycle(0, (k == 37), 1, 1, "t1");
            if (k == N - 2) chk("t1_valid_early", 32'(pos_valid), 32'd0);
        end
        chk("t1_valid", 32'(pos_valid), 32'd1);
        chk("t1_data",  32'(pos_data),  32'd37);
        cycle(0, 0, 1, 1, "t1");
        chk("t1_valid_drop", 32'(pos_valid), 32'd0);

        // Randomized: irregular syncs, random pulses, ready and ena.
        since_fs = 0; target = 0; hold = 0;
        for (int c = 0; c < 24000; c++) begin
            if (c == 12000) begin
                // Asynchronous mid-run reset: outputs clear without a clock edge.
                rst = 1'b1;
                model_reset();
                #1;
                compare_all("async_rst");
                cycle(0, 1, 1, 1, "in_rst");
                cycle(0, 0, 1, 1, "in_rst");
                rst = 1'b0;
                since_fs = 0; target = 600;   // pulses before the next sync are ignored
            end
            fs = (since_fs == target);
            if (fs) begin
                since_fs = 0;
                case ($urandom_range(0, 9))
                    6:       target = $urandom_range(1, N - 1);
                    7:       target = 2 * N;
                    8:       target = N + 44;
                    default: target = N;
                endcase
            end
            if (hold > 0) begin
                pin = 1; hold--;
            end else if ($urandom_range(0, 149) == 0) begin
                pin = 1; hold = $urandom_range(0, 2);
            end else begin
                pin = 0;
            end
            cycle(fs, pin, ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) != 0), "rand");
            since_fs++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
